// File: rtl/rgu_pkg.sv
// -----------------------------------------------------------------------------
// rgu_pkg
// Shared types and defaults for the reset-request front end (rgu_rst_req_ctrl)
// and its per-module pulse stretcher.
//   - reset_num_main : number of main reset domains in this chip
//   - RST_NUM_DEF    : default width of the per-module request vectors
//   - SW_RST_KEY_DEF : key that must accompany a software reset write
//   - rst_cause_e    : sticky reset cause encoding
//   - glb_state_e    : global request FSM states
// -----------------------------------------------------------------------------
package rgu_pkg;

    localparam int unsigned reset_num_main = 13;
    localparam int unsigned RST_NUM_DEF    = reset_num_main;

    localparam logic [15:0] SW_RST_KEY_DEF = 16'h5A5A;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_WDT = 2'b01,
        CAUSE_SW  = 2'b10
    } rst_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SW_HOLD,
        ST_WDT_HOLD,
        ST_QUIET
    } glb_state_e;

endpackage : rgu_pkg

// File: rtl/rgu_pulse_stretch.sv
// -----------------------------------------------------------------------------
// rgu_pulse_stretch
// Turns a one-cycle soft-reset strobe into a request level of CNT cycles.
// A retrigger while active reloads the counter and so extends the pulse.
// flush_i forces the counter to zero and discards any trigger in that cycle.
//
// Ports:
//   clk_i    in   system clock
//   rst_n_i  in   asynchronous active-low reset
//   trig_i   in   one-cycle trigger strobe
//   en_i     in   trigger enable; 0 discards the trigger
//   flush_i  in   clear counter, ignore trigger
//   req_o    out  stretched request, high while the counter is non-zero
// -----------------------------------------------------------------------------
module rgu_pulse_stretch #(
    parameter int unsigned CNT = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic trig_i,
    input  logic en_i,
    input  logic flush_i,
    output logic req_o
);

    localparam int unsigned     CW   = $clog2(CNT + 1);
    localparam logic [CW-1:0]   LOAD = CW'(CNT);

    logic [CW-1:0] cnt_q;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else if (trig_i && en_i) begin
            cnt_q <= LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Counter is a flop, so the request rises one cycle after the trigger.
    assign req_o = (cnt_q != '0);

endmodule : rgu_pulse_stretch

// File: rtl/rgu_rst_req_ctrl.sv
// -----------------------------------------------------------------------------
// rgu_rst_req_ctrl
// Reset-request front end ahead of the main reset generation unit. Qualifies
// keyed software reset writes, the watchdog bite and per-module soft-reset
// strobes, and turns them into clean stretched request levels. A sticky cause
// register survives the resets requested here since it only sees rst_n_i.
//
// Ports:
//   clk_i           in   system clock
//   rst_n_i         in   asynchronous active-low reset (synchronised POR)
//   sw_rst_trig_i   in   one-cycle software global reset strobe
//   sw_rst_key_i    in   [15:0] key written with the software trigger
//   wdt_rst_i       in   watchdog bite, pulse or level
//   mod_rst_trig_i  in   [RST_NUM-1:0] per-module soft-reset strobes
//   mod_rst_en_i    in   [RST_NUM-1:0] per-module trigger enables
//   cause_clr_i     in   one-cycle strobe clearing the cause to POR
//   sw_rst_req_o    out  stretched software global reset request
//   wdt_rst_req_o   out  stretched watchdog global reset request
//   mod_rst_req_o   out  [RST_NUM-1:0] stretched per-module requests
//   rst_cause_o     out  [1:0] sticky cause: 00 POR, 01 WDT, 10 SW
//   glb_busy_o      out  high whenever the global FSM is not idle
// -----------------------------------------------------------------------------
module rgu_rst_req_ctrl
    import rgu_pkg::*;
#(
    parameter int unsigned RST_NUM       = RST_NUM_DEF,
    parameter logic [15:0] SW_RST_KEY    = SW_RST_KEY_DEF,
    parameter int unsigned GLB_PULSE_CNT = 16,
    parameter int unsigned QUIET_CNT     = 32,
    parameter int unsigned MOD_PULSE_CNT = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               sw_rst_trig_i,
    input  logic [15:0]        sw_rst_key_i,
    input  logic               wdt_rst_i,
    input  logic [RST_NUM-1:0] mod_rst_trig_i,
    input  logic [RST_NUM-1:0] mod_rst_en_i,
    input  logic               cause_clr_i,
    output logic               sw_rst_req_o,
    output logic               wdt_rst_req_o,
    output logic [RST_NUM-1:0] mod_rst_req_o,
    output logic [1:0]         rst_cause_o,
    output logic               glb_busy_o
);

    // Both global counts are limited to 1..255, so one 8-bit counter serves
    // the hold phase and the quiet phase. Loads are count-1 because the
    // terminal cycle is the one where the counter reads zero.
    localparam int unsigned         GLB_CW     = 8;
    localparam logic [GLB_CW-1:0]   HOLD_LOAD  = GLB_CW'(GLB_PULSE_CNT - 1);
    localparam logic [GLB_CW-1:0]   QUIET_LOAD = GLB_CW'(QUIET_CNT - 1);

    glb_state_e        state_q;
    logic [GLB_CW-1:0] glb_cnt_q;
    rst_cause_e        cause_q;

    logic in_idle;
    logic glb_hold;
    logic wdt_accept;
    logic sw_accept;

    assign in_idle  = (state_q == ST_IDLE);
    assign glb_hold = (state_q == ST_SW_HOLD) || (state_q == ST_WDT_HOLD);

    // Watchdog has priority; a valid SW trigger in the same cycle is lost.
    assign wdt_accept = in_idle && wdt_rst_i;
    assign sw_accept  = in_idle && !wdt_rst_i && sw_rst_trig_i
                        && (sw_rst_key_i == SW_RST_KEY);

    // Global FSM. Request and busy outputs are registered alongside the
    // state so they change in the same cycle as the state they reflect.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            glb_cnt_q     <= '0;
            sw_rst_req_o  <= 1'b0;
            wdt_rst_req_o <= 1'b0;
            glb_busy_o    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wdt_accept) begin
                        state_q       <= ST_WDT_HOLD;
                        glb_cnt_q     <= HOLD_LOAD;
                        wdt_rst_req_o <= 1'b1;
                        glb_busy_o    <= 1'b1;
                    end else if (sw_accept) begin
                        state_q      <= ST_SW_HOLD;
                        glb_cnt_q    <= HOLD_LOAD;
                        sw_rst_req_o <= 1'b1;
                        glb_busy_o   <= 1'b1;
                    end
                end

                ST_SW_HOLD, ST_WDT_HOLD: begin
                    if (glb_cnt_q == '0) begin
                        state_q       <= ST_QUIET;
                        glb_cnt_q     <= QUIET_LOAD;
                        sw_rst_req_o  <= 1'b0;
                        wdt_rst_req_o <= 1'b0;
                    end else begin
                        glb_cnt_q <= glb_cnt_q - GLB_CW'(1);
                    end
                end

                ST_QUIET: begin
                    if (glb_cnt_q == '0) begin
                        state_q    <= ST_IDLE;
                        glb_busy_o <= 1'b0;
                    end else begin
                        glb_cnt_q <= glb_cnt_q - GLB_CW'(1);
                    end
                end

                default: begin
                    state_q       <= ST_IDLE;
                    glb_cnt_q     <= '0;
                    sw_rst_req_o  <= 1'b0;
                    wdt_rst_req_o <= 1'b0;
                    glb_busy_o    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky cause: an acceptance beats a simultaneous clear strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cause_q <= CAUSE_POR;
        end else if (wdt_accept) begin
            cause_q <= CAUSE_WDT;
        end else if (sw_accept) begin
            cause_q <= CAUSE_SW;
        end else if (cause_clr_i) begin
            cause_q <= CAUSE_POR;
        end
    end

    assign rst_cause_o = cause_q;

    // Per-module stretchers are flushed while a global reset is held, since
    // the global reset already covers every module.
    for (genvar i = 0; i < RST_NUM; i++) begin : g_mod
        rgu_pulse_stretch #(
            .CNT (MOD_PULSE_CNT)
        ) u_stretch (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .trig_i  (mod_rst_trig_i[i]),
            .en_i    (mod_rst_en_i[i]),
            .flush_i (glb_hold),
            .req_o   (mod_rst_req_o[i])
        );
    end

endmodule : rgu_rst_req_ctrl

// File: tb/tb_rgu_rst_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rgu_rst_req_ctrl
// Directed stimulus for rgu_rst_req_ctrl. Each scenario pushes the output
// changes it expects (cycle, signal, new value) into a scoreboard queue; a
// monitor on the falling clock edge detects every output change and pops the
// queue to compare. Cycle n is the interval after the n-th rising edge.
// -----------------------------------------------------------------------------
module tb_rgu_rst_req_ctrl;

    localparam int unsigned RST_NUM = 13;

    localparam int SIG_SW    = 0;
    localparam int SIG_WDT   = 1;
    localparam int SIG_MOD   = 2;
    localparam int SIG_CAUSE = 3;
    localparam int SIG_BUSY  = 4;

    typedef struct {
        int          cyc;
        int          sig;
        logic [15:0] val;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sw_rst_trig;
    logic [15:0]        sw_rst_key;
    logic               wdt_rst;
    logic [RST_NUM-1:0] mod_rst_trig;
    logic [RST_NUM-1:0] mod_rst_en;
    logic               cause_clr;
    logic               sw_rst_req;
    logic               wdt_rst_req;
    logic [RST_NUM-1:0] mod_rst_req;
    logic [1:0]         rst_cause;
    logic               glb_busy;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] cur  [5];
    logic [15:0] prev [5];
    bit          first_sample = 1'b1;

    rgu_rst_req_ctrl #(
        .RST_NUM       (RST_NUM),
        .SW_RST_KEY    (16'h5A5A),
        .GLB_PULSE_CNT (16),
        .QUIET_CNT     (32),
        .MOD_PULSE_CNT (8)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .sw_rst_trig_i  (sw_rst_trig),
        .sw_rst_key_i   (sw_rst_key),
        .wdt_rst_i      (wdt_rst),
        .mod_rst_trig_i (mod_rst_trig),
        .mod_rst_en_i   (mod_rst_en),
        .cause_clr_i    (cause_clr),
        .sw_rst_req_o   (sw_rst_req),
        .wdt_rst_req_o  (wdt_rst_req),
        .mod_rst_req_o  (mod_rst_req),
        .rst_cause_o    (rst_cause),
        .glb_busy_o     (glb_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(input int s);
        case (s)
            SIG_SW:    return "sw_rst_req";
            SIG_WDT:   return "wdt_rst_req";
            SIG_MOD:   return "mod_rst_req";
            SIG_CAUSE: return "rst_cause";
            SIG_BUSY:  return "glb_busy";
            default:   return "unknown";
        endcase
    endfunction

    task automatic expect_chg(input int c, input int s, input logic [15:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    // Drive-side helper: returns on the falling edge of cycle n.
    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check(input int s, input logic [15:0] v);
        exp_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected %s: cycle %0d value %0h, no change expected",
                     sig_name(s), cyc, v);
        end else begin
            e = sb_q.pop_front();
            if (e.sig != s || e.cyc != cyc || e.val !== v) begin
                miscompares++;
                $display("FAIL %s: got %s=%0h at cycle %0d, expected %s=%0h at cycle %0d",
                         sig_name(e.sig), sig_name(s), v, cyc,
                         sig_name(e.sig), e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every output change is a response to be scored. The first
    // sample (in reset) is scored in full to check the reset values.
    always @(negedge clk) begin
        cur[SIG_SW]    = {15'd0, sw_rst_req};
        cur[SIG_WDT]   = {15'd0, wdt_rst_req};
        cur[SIG_MOD]   = {3'd0, mod_rst_req};
        cur[SIG_CAUSE] = {14'd0, rst_cause};
        cur[SIG_BUSY]  = {15'd0, glb_busy};
        for (int i = 0; i < 5; i++) begin
            if (first_sample || cur[i] !== prev[i]) begin
                check(i, cur[i]);
                prev[i] = cur[i];
            end
        end
        first_sample = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b1;
        sw_rst_trig  = 1'b0;
        sw_rst_key   = 16'h0000;
        wdt_rst      = 1'b0;
        mod_rst_trig = '0;
        mod_rst_en   = 13'h1F7F;  // bit 7 disabled
        cause_clr    = 1'b0;
        #1 rst_n = 1'b0;

        // Reset values
        expect_chg(1, SIG_SW, 0);
        expect_chg(1, SIG_WDT, 0);
        expect_chg(1, SIG_MOD, 0);
        expect_chg(1, SIG_CAUSE, 0);
        expect_chg(1, SIG_BUSY, 0);
        at_cyc(3);
        rst_n = 1'b1;

        // Keyed SW reset: request 11..26, quiet 27..58, idle at 59
        expect_chg(11, SIG_SW, 1);
        expect_chg(11, SIG_CAUSE, 2);
        expect_chg(11, SIG_BUSY, 1);
        expect_chg(27, SIG_SW, 0);
        expect_chg(59, SIG_BUSY, 0);
        at_cyc(10); sw_rst_trig = 1'b1; sw_rst_key = 16'h5A5A;
        at_cyc(11); sw_rst_trig = 1'b0;

        // Wrong key: no response at all
        at_cyc(70); sw_rst_trig = 1'b1; sw_rst_key = 16'h1234;
        at_cyc(71); sw_rst_trig = 1'b0;

        // WDT and valid SW together: WDT wins; SW during QUIET ignored
        expect_chg(81, SIG_WDT, 1);
        expect_chg(81, SIG_CAUSE, 1);
        expect_chg(81, SIG_BUSY, 1);
        expect_chg(97, SIG_WDT, 0);
        expect_chg(129, SIG_BUSY, 0);
        at_cyc(80); wdt_rst = 1'b1; sw_rst_trig = 1'b1; sw_rst_key = 16'h5A5A;
        at_cyc(81); wdt_rst = 1'b0; sw_rst_trig = 1'b0;
        at_cyc(100); sw_rst_trig = 1'b1;
        at_cyc(101); sw_rst_trig = 1'b0;

        // Module bit 4 retriggered (high 141..152); bit 7 disabled stays low
        expect_chg(141, SIG_MOD, 16'h0010);
        expect_chg(153, SIG_MOD, 16'h0000);
        at_cyc(140); mod_rst_trig = 13'h0090;
        at_cyc(141); mod_rst_trig = '0;
        at_cyc(144); mod_rst_trig = 13'h0090;
        at_cyc(145); mod_rst_trig = '0;

        // Cause clear
        expect_chg(161, SIG_CAUSE, 0);
        at_cyc(160); cause_clr = 1'b1;
        at_cyc(161); cause_clr = 1'b0;

        // Bits 2,3 active then WDT bite: flushed the cycle after WDT_HOLD
        // entry; trigger in hold ignored; trigger in QUIET accepted
        expect_chg(171, SIG_MOD, 16'h000C);
        expect_chg(174, SIG_WDT, 1);
        expect_chg(174, SIG_CAUSE, 1);
        expect_chg(174, SIG_BUSY, 1);
        expect_chg(175, SIG_MOD, 16'h0000);
        expect_chg(190, SIG_WDT, 0);
        expect_chg(201, SIG_MOD, 16'h0020);
        expect_chg(209, SIG_MOD, 16'h0000);
        expect_chg(222, SIG_BUSY, 0);
        at_cyc(170); mod_rst_trig = 13'h000C;
        at_cyc(171); mod_rst_trig = '0;
        at_cyc(173); wdt_rst = 1'b1;
        at_cyc(174); wdt_rst = 1'b0;
        at_cyc(180); mod_rst_trig = 13'h0010;
        at_cyc(181); mod_rst_trig = '0;
        at_cyc(200); mod_rst_trig = 13'h0020;
        at_cyc(201); mod_rst_trig = '0;

        // Cause clear after WDT event
        expect_chg(231, SIG_CAUSE, 0);
        at_cyc(230); cause_clr = 1'b1;
        at_cyc(231); cause_clr = 1'b0;

        // Clear and acceptance together: acceptance wins; then async reset
        // mid-pulse drops everything before the next rising edge
        expect_chg(241, SIG_SW, 1);
        expect_chg(241, SIG_CAUSE, 2);
        expect_chg(241, SIG_BUSY, 1);
        expect_chg(245, SIG_SW, 0);
        expect_chg(245, SIG_CAUSE, 0);
        expect_chg(245, SIG_BUSY, 0);
        at_cyc(240); sw_rst_trig = 1'b1; sw_rst_key = 16'h5A5A; cause_clr = 1'b1;
        at_cyc(241); sw_rst_trig = 1'b0; cause_clr = 1'b0;
        at_cyc(244);
        @(posedge clk);
        #2 rst_n = 1'b0;
        at_cyc(248); rst_n = 1'b1;

        // FSM restarts from IDLE after reset
        expect_chg(251, SIG_SW, 1);
        expect_chg(251, SIG_CAUSE, 2);
        expect_chg(251, SIG_BUSY, 1);
        expect_chg(267, SIG_SW, 0);
        expect_chg(299, SIG_BUSY, 0);
        at_cyc(250); sw_rst_trig = 1'b1;
        at_cyc(251); sw_rst_trig = 1'b0;

        // WDT level held through QUIET starts a new hold on return to IDLE
        expect_chg(311, SIG_WDT, 1);
        expect_chg(311, SIG_CAUSE, 1);
        expect_chg(311, SIG_BUSY, 1);
        expect_chg(327, SIG_WDT, 0);
        expect_chg(359, SIG_BUSY, 0);
        expect_chg(360, SIG_WDT, 1);
        expect_chg(360, SIG_BUSY, 1);
        expect_chg(376, SIG_WDT, 0);
        expect_chg(408, SIG_BUSY, 0);
        at_cyc(310); wdt_rst = 1'b1;
        at_cyc(360); wdt_rst = 1'b0;

        at_cyc(420);
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing %s: expected %0h at cycle %0d, never seen",
                     sig_name(e.sig), e.val, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rgu_rst_req_ctrl
